rr_arbiter_n: RTL and testbench
===============================

RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, legal range 2..16.
REQ-002 SHALL have parameter QUANTUM, default 4: maximum consecutive cycles one requester holds the grant while others wait, legal range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, N: request vector; bit i high means requester i wants the resource.
REQ-006 SHALL have port gnt, output, N: registered one-hot-or-zero grant vector.
REQ-007 SHALL have port gnt_valid, output, 1: registered; high when any gnt bit is high.
REQ-008 SHALL have port gnt_id, output, max(1,clog2(N)): registered index of the granted requester; 0 when gnt_valid is low.

Function
REQ-009 SHALL keep internal state: holder index, hold counter (8 bits, saturating), and search pointer ptr (index where the next arbitration search starts).
REQ-010 SHALL make gnt, gnt_valid and gnt_id flops, never combinational from req.
REQ-011 SHALL, from idle, assert gnt to a request sampled on edge t at edge t (one-edge latency).
REQ-012 SHALL, from idle, grant the first set req bit found searching ptr, ptr+1, ..., wrapping mod N.
REQ-013 SHALL keep the current holder granted while its req stays high and the hold counter is below QUANTUM-1.
REQ-014 SHALL, when the holder's counter reaches QUANTUM-1, move the grant to the first other requester searching from holder+1 mod N; if no other requester exists, keep the holder granted and saturate the counter.
REQ-015 SHALL, when the holder drops req, move the grant on the same edge to the first requester searching from holder+1 mod N, or go idle (gnt=0) if none.
REQ-016 SHALL clear the hold counter to 0 on every new grant, including a re-grant to the same index after an idle cycle.
REQ-017 SHALL set ptr to (granted index+1) mod N on every new grant, so the most recent holder has lowest priority.
REQ-018 SHALL never assert more than one gnt bit.
REQ-019 SHALL never grant a requester whose req bit was low at the deciding edge.
REQ-020 SHALL, with all N requesters continuously active, grant each one exactly QUANTUM cycles per N*QUANTUM-cycle rotation.
REQ-021 SHALL wrap the search from index N-1 to index 0.
REQ-022 SHALL treat simultaneous holder release and new requests per REQ-015 with no idle bubble.

Reset
REQ-023 SHALL, while reset is high, drive gnt=0, gnt_valid=0, gnt_id=0, hold counter=0 and ptr=0, independent of clk.
REQ-024 SHALL, on reset mid-grant, drop the grant immediately (asynchronously).
REQ-025 SHALL, after reset deasserts, evaluate the first arbitration at the next rising edge from ptr=0.

Configuration
REQ-026 SHALL, when macro RR_ARBITER_LOCK_EN is defined, add input lock (1 bit); while lock and the holder's req are both high, the holder keeps the grant regardless of QUANTUM and the counter holds its value.
REQ-027 SHALL, when RR_ARBITER_LOCK_EN is defined, ignore lock while gnt_valid is low.
REQ-028 SHALL, when RR_ARBITER_LOCK_EN is not defined, have no lock port and apply the quantum behaviour only.

Verification
REQ-029 SHALL cover reset then req=4'b0100 -> gnt=4'b0100, gnt_id=2, gnt_valid=1 at the first edge; held while req holds.
REQ-030 SHALL cover N=4, QUANTUM=4, req=4'b1111 for 32 cycles -> gnt rotates 0001 x4, 0010 x4, 0100 x4, 1000 x4, then repeats.
REQ-031 SHALL cover a sole requester with req=4'b0010 held 10 cycles -> gnt=4'b0010 for all 10 cycles, no drop at the quantum boundary.
REQ-032 SHALL cover holder 3 releasing while req=4'b0011 -> next edge gnt=4'b0001 (wrap), no idle cycle.
REQ-033 SHALL cover reset pulsed mid-grant -> gnt=0 immediately; after release with req=4'b1010 -> gnt=4'b0010.
REQ-034 SHALL cover, with RR_ARBITER_LOCK_EN defined, lock=1, holder 0 and req=4'b0011 for 8 cycles -> gnt=4'b0001 all 8; lock=0 -> gnt=4'b0010 within QUANTUM cycles.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter over N requesters with a per-holder quantum and registered grant outputs.
// Optional build macro RR_ARBITER_LOCK_EN adds a lock input that pins the grant to the current holder.
module rr_arbiter_n #(
  parameter int N       = 4,
  parameter int QUANTUM = 4,
  localparam int IDW    = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
`ifdef RR_ARBITER_LOCK_EN
  input  logic           lock,
`endif
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id
);

  localparam logic [7:0] QM1 = 8'(QUANTUM - 1);

  logic [N-1:0]   r_gnt;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  logic [7:0]     r_cnt;
  logic [IDW-1:0] r_ptr;

  logic [N-1:0]   w_nxt_gnt;
  logic           w_nxt_valid;
  logic [IDW-1:0] w_nxt_id;
  logic [7:0]     w_nxt_cnt;
  logic [IDW-1:0] w_nxt_ptr;
  logic [IDW-1:0] w_h_next;
  logic [IDW:0]   w_idle_hit;
  logic [IDW:0]   w_move_hit;
  logic [N-1:0]   w_others;
  logic           w_hold_req;
  logic           w_lock;

  // Returns {found, index} of the first set bit of v scanning start, start+1, ... mod N.
  function automatic logic [IDW:0] find_first(input logic [N-1:0] v, input logic [IDW-1:0] start);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (v[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
`ifdef RR_ARBITER_LOCK_EN
    w_lock = lock;
`else
    w_lock = 1'b0;
`endif
    w_h_next    = (r_id == IDW'(N - 1)) ? '0 : r_id + 1'b1;
    w_hold_req  = |(req & r_gnt);
    w_others    = req & ~r_gnt;
    w_idle_hit  = find_first(req, r_ptr);
    w_move_hit  = find_first(w_others, w_h_next);
    w_nxt_valid = r_valid;
    w_nxt_id    = r_id;
    w_nxt_cnt   = r_cnt;
    w_nxt_ptr   = r_ptr;

    if (!r_valid) begin
      if (w_idle_hit[IDW]) begin
        w_nxt_valid = 1'b1;
        w_nxt_id    = w_idle_hit[IDW-1:0];
        w_nxt_cnt   = '0;
        w_nxt_ptr   = (w_idle_hit[IDW-1:0] == IDW'(N - 1)) ? '0 : w_idle_hit[IDW-1:0] + 1'b1;
      end
    end else if (w_lock && w_hold_req) begin
      w_nxt_cnt = r_cnt;
    end else if (w_hold_req && (r_cnt < QM1)) begin
      w_nxt_cnt = r_cnt + 8'd1;
    end else if (w_move_hit[IDW]) begin
      // Quantum expiry or release both hand over to the next requester on this edge.
      w_nxt_valid = 1'b1;
      w_nxt_id    = w_move_hit[IDW-1:0];
      w_nxt_cnt   = '0;
      w_nxt_ptr   = (w_move_hit[IDW-1:0] == IDW'(N - 1)) ? '0 : w_move_hit[IDW-1:0] + 1'b1;
    end else if (w_hold_req) begin
      w_nxt_cnt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    end else begin
      w_nxt_valid = 1'b0;
      w_nxt_id    = '0;
    end

    w_nxt_gnt = '0;
    if (w_nxt_valid) w_nxt_gnt[w_nxt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_gnt   <= w_nxt_gnt;
      r_valid <= w_nxt_valid;
      r_id    <= w_nxt_id;
      r_cnt   <= w_nxt_cnt;
      r_ptr   <= w_nxt_ptr;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_id    = r_id;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n (N=4, QUANTUM=4): driver pushes expected grants, negedge monitor checks.
module tb_rr_arbiter_n;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
`ifdef RR_ARBITER_LOCK_EN
  logic       lock;
`endif

  logic [6:0] exp_q[$];
  string      name_q[$];
  int         n_vec;
  int         n_bad;

  rr_arbiter_n #(.N(4), .QUANTUM(4)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef RR_ARBITER_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs an expected grant vector as {gnt, valid, id}.
  function automatic logic [6:0] enc(input logic [3:0] g);
    logic [1:0] id;
    case (g)
      4'b0010: id = 2'd1;
      4'b0100: id = 2'd2;
      4'b1000: id = 2'd3;
      default: id = 2'd0;
    endcase
    return {g, |g, id};
  endfunction

  // driver: apply req for one edge and queue the grant expected after it
  task automatic step(input logic [3:0] r, input logic [3:0] g, input string nm);
    req = r;
    exp_q.push_back(enc(g));
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [6:0] e;
    string      nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if ({gnt, gnt_valid, gnt_id} !== e) begin
        n_bad++;
        $display("FAIL %s: got gnt=%b valid=%b id=%0d, want gnt=%b valid=%b id=%0d",
                 nm, gnt, gnt_valid, gnt_id, e[6:3], e[2], e[1:0]);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    req   = 4'b0000;
`ifdef RR_ARBITER_LOCK_EN
    lock  = 1'b0;
`endif
    @(negedge clk);
    #1;
    step(4'b1111, 4'b0000, "reset_state");

    reset = 1'b0;
    for (int i = 0; i < 32; i++)
      step(4'b1111, 4'b0001 << ((i / 4) % 4), "rotate_all");

    step(4'b0000, 4'b0000, "idle_after_release");
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0100, "first_edge_req2");
    for (int i = 0; i < 10; i++) step(4'b0010, 4'b0010, "sole_req_no_drop");
    step(4'b1000, 4'b1000, "move_to_3");
    step(4'b0011, 4'b0001, "wrap_3_to_0");
    step(4'b0011, 4'b0001, "quantum_hold");
    step(4'b0011, 4'b0001, "quantum_hold");
    step(4'b0011, 4'b0001, "quantum_hold");
    for (int i = 0; i < 4; i++) step(4'b0011, 4'b0010, "quantum_move");
    step(4'b0011, 4'b0001, "quantum_back");

    // async reset mid-grant: let one edge pass, then raise reset between edges
    @(posedge clk);
    #1;
    reset = 1'b1;
    req   = 4'b1010;
    exp_q.push_back(enc(4'b0000));
    name_q.push_back("async_reset_drop");
    @(negedge clk);
    #1;
    step(4'b1010, 4'b0000, "reset_held");
    reset = 1'b0;
    step(4'b1010, 4'b0010, "after_reset_ptr0");
    step(4'b0100, 4'b0100, "release_no_bubble");
    step(4'b0000, 4'b0000, "idle_again");
    step(4'b0101, 4'b0001, "search_from_ptr3");

`ifdef RR_ARBITER_LOCK_EN
    lock = 1'b1;
    for (int i = 0; i < 8; i++) step(4'b0011, 4'b0001, "lock_hold");
    lock = 1'b0;
    for (int i = 0; i < 3; i++) step(4'b0011, 4'b0001, "unlock_finish_quantum");
    step(4'b0011, 4'b0010, "unlock_move");
`endif

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
